// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage. Holds the program counter, issues single-word reads
// to instruction memory over a req/ack handshake, registers the returned word
// and presents it to the decoder until the downstream stage consumes it.
// Redirects from branch/jump resolution replace the PC at any time.
//
// Optional feature (compile-time macro IFETCH_ALIGN_CHECK_EN):
//   defined     - a redirect whose target has bits 1:0 != 0 sets the sticky
//                 misalign_err flag (cleared only by reset); the redirect still
//                 proceeds with bits 1:0 forced to zero.
//   not defined - misalign_err is tied to 0; misaligned targets are silently
//                 aligned.
//
// Parameters:
//   RESET_PC   PC loaded on reset (bits 1:0 must be zero)
//   CNT_W      width of the retired-instruction counter
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req          read request to instruction memory
//   imem_addr         word-aligned byte address of the request
//   imem_ack          read data valid (only meaningful while imem_req=1)
//   imem_rdata        instruction word returned by memory
//   stall             downstream cannot consume this cycle
//   redirect_valid    load redirect_pc into the PC this cycle
//   redirect_pc       redirect target
//   instr_valid       instr holds a valid, not yet consumed instruction
//   instr             registered instruction word
//   instr_pc          address instr was fetched from
//   OP                instr[31:26]
//   funct             instr[5:0]
//   retired           number of consumed instructions (wraps)
//   misalign_err      sticky misaligned-redirect flag
//   state_dbg         FSM state (0 = FETCH, 1 = HOLD)
//
// Handshake: a memory transfer completes on a rising edge where imem_req=1 and
// imem_ack=1. imem_req and imem_addr are decoded from registers only, so they
// never depend on imem_ack within a cycle. A transfer abandoned by a redirect
// is treated as complete; the next imem_req starts a new transfer. Downstream
// consumes the held instruction on a rising edge where instr_valid=1 and
// stall=0.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic [5:0]       OP,
  output logic [5:0]       funct,
  output logic [CNT_W-1:0] retired,
  output logic             misalign_err,
  output logic             state_dbg
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_nxt;
  logic             run_q;
  logic [31:0]      pc_q, pc_nxt;
  logic [31:0]      instr_q, instr_nxt;
  logic [31:0]      instr_pc_q, instr_pc_nxt;
  logic             valid_q, valid_nxt;
  logic [CNT_W-1:0] retired_q, retired_nxt;
  logic             accept;

  // run_q holds the request low for the first cycle out of reset, so the
  // first request appears after the first rising edge following release.
  assign imem_req  = run_q && (state_q == FETCH);
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ack;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      run_q      <= 1'b0;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      valid_q    <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_nxt;
      run_q      <= 1'b1;
      pc_q       <= pc_nxt;
      instr_q    <= instr_nxt;
      instr_pc_q <= instr_pc_nxt;
      valid_q    <= valid_nxt;
      retired_q  <= retired_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state_q;
    pc_nxt       = pc_q;
    instr_nxt    = instr_q;
    instr_pc_nxt = instr_pc_q;
    valid_nxt    = valid_q;
    retired_nxt  = retired_q;

    case (state_q)
      FETCH: begin
        if (accept) begin
          instr_nxt    = imem_rdata;
          instr_pc_nxt = pc_q;
          pc_nxt       = pc_q + 32'd4;
          valid_nxt    = 1'b1;
          state_nxt    = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          valid_nxt   = 1'b0;
          retired_nxt = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_nxt   = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase

    // Redirect wins over everything except the retire count: a word arriving
    // in the same cycle is discarded, but a simultaneous consume still counts.
    if (redirect_valid) begin
      pc_nxt       = {redirect_pc[31:2], 2'b00};
      instr_nxt    = instr_q;
      instr_pc_nxt = instr_pc_q;
      valid_nxt    = 1'b0;
      state_nxt    = FETCH;
    end
  end

  // ---------------------------------------------------------------------------
  // Misaligned redirect flag
  // ---------------------------------------------------------------------------
`ifdef IFETCH_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_q;
`else
  // Low target bits are simply dropped in this build.
  logic unused_redirect_lo;
  assign unused_redirect_lo = ^redirect_pc[1:0];
  assign misalign_err       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign OP          = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign retired     = retired_q;
  assign state_dbg   = state_q;

endmodule
